elevator_request_queue: RTL and testbench

- Upstream stage of the elevator controller for a 4-floor car.
- Debounces and latches hall calls (OutUp, OutDown) and car calls (InNum) into pending-request registers.
- Runs the travel-direction state machine and tells the controller which floor to head for and whether to stop at the current floor.
- Clears requests when the controller reports a floor was served.

---
 rtl/elevator_pkg.sv | 43 ++++
 rtl/btn_debounce.sv | 33 +++
 rtl/elevator_request_queue.sv | 131 +++++++++++++
 tb/tb_elevator_request_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings, sizes and floor-search helpers for the elevator request queue.
package elevator_pkg;

    localparam int N_FLOOR        = 4;
    localparam int FLOOR_W        = 2;
    localparam int DEB_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    function automatic logic [N_FLOOR-1:0] above_mask(input logic [FLOOR_W-1:0] cur);
        logic [N_FLOOR-1:0] m;
        for (int i = 0; i < N_FLOOR; i++) m[i] = (i > int'(cur));
        return m;
    endfunction

    function automatic logic [N_FLOOR-1:0] below_mask(input logic [FLOOR_W-1:0] cur);
        logic [N_FLOOR-1:0] m;
        for (int i = 0; i < N_FLOOR; i++) m[i] = (i < int'(cur));
        return m;
    endfunction

    // Lowest set bit index of v, or fallback when v is empty.
    function automatic logic [FLOOR_W-1:0] lowest_idx(input logic [N_FLOOR-1:0] v,
                                                      input logic [FLOOR_W-1:0] fallback);
        logic [FLOOR_W-1:0] r;
        r = fallback;
        for (int i = N_FLOOR - 1; i >= 0; i--) if (v[i]) r = FLOOR_W'(i);
        return r;
    endfunction

    function automatic logic [FLOOR_W-1:0] highest_idx(input logic [N_FLOOR-1:0] v,
                                                       input logic [FLOOR_W-1:0] fallback);
        logic [FLOOR_W-1:0] r;
        r = fallback;
        for (int i = 0; i < N_FLOOR; i++) if (v[i]) r = FLOOR_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: one-clock press pulse after DEB_CYCLES consecutive high clocks.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [3:0] CNT_MAX  = 4'(DEB_CYCLES);
    localparam logic [3:0] CNT_FIRE = 4'(DEB_CYCLES - 1);

    logic [3:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            // The pulse fires on the edge where the count reaches CNT_MAX, so it is emitted once per hold.
            press <= btn && (cnt == CNT_FIRE);
            if (!btn)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/elevator_request_queue.sv
// Latches debounced hall/car calls, runs the travel-direction FSM and picks Target/StopHere.
// Optional macro REQ_CANCEL_EN: a repeat car-call press cancels the pending call.
module elevator_request_queue
    import elevator_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         OutUp,
    input  logic [3:1]         OutDown,
    input  logic [3:0]         InNum,
    input  logic [FLOOR_W-1:0] CurFloor,
    input  logic               Moving,
    input  logic               Serve,
    output logic [2:0]         ReqUp,
    output logic [3:1]         ReqDown,
    output logic [3:0]         ReqIn,
    output logic [1:0]         Dir,
    output logic [FLOOR_W-1:0] Target,
    output logic               HasReq,
    output logic               StopHere
);

    logic [N_FLOOR-1:0] up_press, down_press, in_press;
    logic [N_FLOOR-1:0] up_q, down_q, in_q;
    logic [N_FLOOR-1:0] up_d, down_d, in_d;
    logic [N_FLOOR-1:0] clr_up, clr_down, clr_in, cancel;
    logic [N_FLOOR-1:0] pend, cur_mask;
    logic               above, below, here;
    logic               stop_d, stop_q, has_q;
    logic [FLOOR_W-1:0] target_d, target_q;
    dir_t               dir_q, next_dir;

    for (genvar i = 0; i < 3; i++) begin : g_up
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk), .rst(rst), .btn(OutUp[i]), .press(up_press[i]));
    end
    for (genvar i = 1; i < 4; i++) begin : g_down
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk), .rst(rst), .btn(OutDown[i]), .press(down_press[i]));
    end
    for (genvar i = 0; i < 4; i++) begin : g_in
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk), .rst(rst), .btn(InNum[i]), .press(in_press[i]));
    end
    assign up_press[3]   = 1'b0;
    assign down_press[0] = 1'b0;

    assign pend     = up_q | down_q | in_q;
    assign cur_mask = N_FLOOR'(1) << CurFloor;
    assign above    = |(pend & above_mask(CurFloor));
    assign below    = |(pend & below_mask(CurFloor));
    assign here     = |(pend & cur_mask);

    always_ff @(posedge clk) begin
        if (!rst) dir_q <= DIR_IDLE;
        else      dir_q <= next_dir;
    end

    // NOTE: assigning defaults first keeps every path covered, so no latch is inferred.
    always_comb begin
        next_dir = dir_q;
        if (!Moving) begin
            unique case (dir_q)
                DIR_IDLE: if (above) next_dir = DIR_UP;   else if (below) next_dir = DIR_DOWN;
                DIR_UP:   if (!above) next_dir = below ? DIR_DOWN : DIR_IDLE;
                DIR_DOWN: if (!below) next_dir = above ? DIR_UP : DIR_IDLE;
                default:  next_dir = DIR_IDLE;
            endcase
        end
    end

    // Serve clears the hall call for the current and the upcoming direction; clears beat presses.
    always_comb begin
        clr_up   = '0;
        clr_down = '0;
        clr_in   = '0;
        cancel   = '0;
        if (Serve && !Moving) begin
            clr_in = cur_mask;
            if (dir_q != DIR_DOWN || next_dir == DIR_UP)   clr_up   = cur_mask;
            if (dir_q != DIR_UP   || next_dir == DIR_DOWN) clr_down = cur_mask;
        end
`ifdef REQ_CANCEL_EN
        cancel = in_press & in_q & ~(Moving ? '0 : cur_mask);
`endif
        up_d   = (up_q | up_press) & ~clr_up & 4'b0111;
        down_d = (down_q | down_press) & ~clr_down & 4'b1110;
        in_d   = (in_q | in_press) & ~cancel & ~clr_in;
    end

    always_comb begin
        stop_d = in_q[CurFloor]
              || (dir_q == DIR_UP   && (up_q[CurFloor]   || (here && !above)))
              || (dir_q == DIR_DOWN && (down_q[CurFloor] || (here && !below)))
              || (dir_q == DIR_IDLE && here);
        unique case (dir_q)
            DIR_UP:   target_d = lowest_idx(pend & above_mask(CurFloor), CurFloor);
            DIR_DOWN: target_d = highest_idx(pend & below_mask(CurFloor), CurFloor);
            default:  target_d = lowest_idx(pend, CurFloor);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            up_q     <= '0;
            down_q   <= '0;
            in_q     <= '0;
            stop_q   <= 1'b0;
            target_q <= '0;
            has_q    <= 1'b0;
        end else begin
            up_q     <= up_d;
            down_q   <= down_d;
            in_q     <= in_d;
            stop_q   <= stop_d;
            target_q <= target_d;
            has_q    <= |pend;
        end
    end

    assign ReqUp    = up_q[2:0];
    assign ReqDown  = down_q[3:1];
    assign ReqIn    = in_q;
    assign Dir      = dir_q;
    assign Target   = target_q;
    assign HasReq   = has_q;
    assign StopHere = stop_q;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue with hand-computed expectations (DEB_CYCLES=2).
module tb_elevator_request_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] OutUp;
    logic [3:1] OutDown;
    logic [3:0] InNum;
    logic [1:0] CurFloor;
    logic       Moving, Serve;
    logic [2:0] ReqUp;
    logic [3:1] ReqDown;
    logic [3:0] ReqIn;
    logic [1:0] Dir, Target;
    logic       HasReq, StopHere;

    int errors = 0;
    int checks = 0;

    elevator_request_queue #(.DEB_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .OutUp(OutUp), .OutDown(OutDown), .InNum(InNum),
        .CurFloor(CurFloor), .Moving(Moving), .Serve(Serve),
        .ReqUp(ReqUp), .ReqDown(ReqDown), .ReqIn(ReqIn), .Dir(Dir),
        .Target(Target), .HasReq(HasReq), .StopHere(StopHere));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; OutUp = '0; OutDown = '0; InNum = '0;
        CurFloor = 2'd0; Moving = 1'b0; Serve = 1'b0;
        tick(); tick();
        check("rst_req_in",  8'(ReqIn),    8'h0);
        check("rst_dir",     8'(Dir),      8'h0);
        check("rst_target",  8'(Target),   8'h0);
        check("rst_hasreq",  8'(HasReq),   8'h0);
        check("rst_stop",    8'(StopHere), 8'h0);
        rst = 1'b1;

        // Car call to floor 3 from floor 0: latency DEB_CYCLES+1.
        InNum = 4'b1000;
        tick(); tick();
        InNum = 4'b0000;
        check("deb_latency_early", 8'(ReqIn), 8'h0);
        tick();
        check("latch_in3",     8'(ReqIn), 8'h8);
        check("dir_before_up", 8'(Dir),   8'h0);
        tick();
        check("dir_up",        8'(Dir),      8'h1);
        check("target_3",      8'(Target),   8'h3);
        check("hasreq_1",      8'(HasReq),   8'h1);
        check("stop_floor0",   8'(StopHere), 8'h0);

        // One-clock glitch on InNum[2] must not register.
        InNum = 4'b0100;
        tick();
        InNum = 4'b0000;
        tick(); tick();
        check("glitch_ignored", 8'(ReqIn), 8'h8);

        // At floor 1 heading up with a down call here and a car call above: no stop.
        CurFloor = 2'd1;
        OutDown = 3'b001;
        tick(); tick();
        OutDown = 3'b000;
        tick();
        check("latch_down1", 8'(ReqDown), 8'h1);
        tick();
        check("stop_pass_down1", 8'(StopHere), 8'h0);
        check("dir_still_up",    8'(Dir),      8'h1);
        check("target_up_3",     8'(Target),   8'h3);

        // Arrive at floor 3 and serve: car call cleared, direction flips to down.
        Moving = 1'b1;
        tick();
        check("dir_hold_moving", 8'(Dir), 8'h1);
        CurFloor = 2'd3; Moving = 1'b0; Serve = 1'b1;
        tick();
        Serve = 1'b0;
        check("serve3_clear_in", 8'(ReqIn),   8'h0);
        check("dir_turn_down",   8'(Dir),     8'h2);
        check("down1_kept",      8'(ReqDown), 8'h1);
        Moving = 1'b1; CurFloor = 2'd1;
        tick();
        Moving = 1'b0;
        tick();
        check("stop_at_down1", 8'(StopHere), 8'h1);
        check("dir_idle_end",  8'(Dir),      8'h0);
        Serve = 1'b1;
        tick();
        Serve = 1'b0;
        check("serve1_clear_down", 8'(ReqDown), 8'h0);
        tick();
        check("hasreq_0", 8'(HasReq), 8'h0);

        // Press and Serve on the same bit in the same clock: clear wins.
        do_reset();
        CurFloor = 2'd0;
        OutUp = 3'b001;
        tick(); tick();
        OutUp = 3'b000; Serve = 1'b1;
        tick();
        Serve = 1'b0;
        check("press_vs_serve", 8'(ReqUp), 8'h0);
        tick();
        check("press_vs_serve_hold", 8'(ReqUp), 8'h0);
        OutUp = 3'b001;
        tick(); tick();
        OutUp = 3'b000;
        tick();
        check("latch_up0", 8'(ReqUp), 8'h1);
        Serve = 1'b1;
        tick();
        Serve = 1'b0;
        check("serve_idle_up0", 8'(ReqUp), 8'h0);

        // Pending 0110 wiped by a mid-operation reset.
        InNum = 4'b0110;
        tick(); tick();
        InNum = 4'b0000;
        tick();
        check("latch_0110", 8'(ReqIn), 8'h6);
        tick();
        check("target_idle_low", 8'(Target), 8'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_req_in", 8'(ReqIn),  8'h0);
        check("midrst_dir",    8'(Dir),    8'h0);
        check("midrst_target", 8'(Target), 8'h0);
        check("midrst_hasreq", 8'(HasReq), 8'h0);

        // Long hold yields exactly one press.
        InNum = 4'b0010;
        repeat (6) tick();
        InNum = 4'b0000;
        tick();
        check("long_hold_once", 8'(ReqIn), 8'h2);

        // Second press on pending car call at floor 2 (not the current floor).
        do_reset();
        CurFloor = 2'd0;
        InNum = 4'b0100;
        tick(); tick();
        InNum = 4'b0000;
        tick();
        check("first_press_in2", 8'(ReqIn), 8'h4);
        InNum = 4'b0100;
        tick(); tick();
        InNum = 4'b0000;
        tick();
`ifdef REQ_CANCEL_EN
        check("second_press_in2", 8'(ReqIn), 8'h0);
`else
        check("second_press_in2", 8'(ReqIn), 8'h4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
